fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit computer: owns the program counter, fetches 13-bit instruction words from program ROM through a ready/valid handshake, holds them in an instruction register, and presents opcode/operand to the combinational control unit. It consumes the control unit's PC_EN / PC_LOAD / HALT decisions and the data-bus jump target to pick the next PC, and stalls on IN/OUT until the I/O side is ready.

## Interface
- ADDR_W, 8, PC / ROM address width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  ROM address, equals pc
- rom_req  out  1  fetch request; high only in FETCH
- rom_data  in  13  instruction word: [12:8] opcode, [7:0] operand
- rom_valid  in  1  rom_data valid; sampled only in FETCH
- opcode  out  5  IR opcode field to control unit
- operand  out  8  IR operand field to control unit
- instr_valid  out  1  high in EXECUTE; control-unit outputs honoured only then
- exec_commit  out  1  one-cycle pulse when the instruction retires; gates all register/RAM/OUT writes
- pc_en  in  1  control unit PC_EN
- pc_load  in  1  control unit PC_LOAD
- halt  in  1  control unit HALT
- jump_target  in  ADDR_W  data-bus value used on pc_load
- io_ready  in  1  I/O device ready; releases IN/OUT stall
- pc  out  ADDR_W  current program counter
- halted  out  1  high in HALTED

## Operation
- States: FETCH, EXECUTE, HALTED. Reset → FETCH.
- FETCH: rom_req=1, rom_addr=pc. When rom_valid=1: IR ← rom_data, → EXECUTE. Otherwise hold; rom_addr stable.
- EXECUTE: instr_valid=1, opcode/operand from IR. Priority, evaluated every EXECUTE cycle:
  - halt=1 → exec_commit=1, → HALTED; pc unchanged.
  - else pc_load=1 → exec_commit=1, pc ← jump_target, → FETCH.
  - else pc_en=1 → exec_commit=1, pc ← pc+1, → FETCH.
  - else (IN/OUT stall): if io_ready=1 → exec_commit=1, pc ← pc+1, → FETCH; else stay in EXECUTE, exec_commit=0.
- HALTED: rom_req=0, instr_valid=0, halted=1; all inputs ignored; exits only via rst.
- pc+1 is modulo 2^ADDR_W (0xFF → 0x00). jump_target loaded verbatim.
- IR changes only on the FETCH→EXECUTE edge; opcode/operand stable for the whole EXECUTE dwell.
- rom_valid ignored outside FETCH; io_ready ignored outside EXECUTE.
- Undefined opcodes pass through unmodified; the control unit's default (pc_en=1) makes them NOPs.

## Timing
- Reset values (cycle after rst sampled high, held while rst high): pc=RESET_PC, IR=0 (opcode 0, operand 0), state FETCH, rom_req=0, instr_valid=0, exec_commit=0, halted=0.
- rom_req, instr_valid, halted, exec_commit are decoded from state and inputs (exec_commit is combinational on EXECUTE + decision inputs); rom_req forced 0 while rst=1.
- First rom_req: first cycle with rst=0.
- Minimum instruction time 2 cycles (1 FETCH with rom_valid same cycle + 1 EXECUTE). Each ROM wait cycle adds 1; each io_ready-low EXECUTE cycle adds 1.
- pc updates on the edge ending the committing EXECUTE cycle; rom_addr shows the new pc in the next FETCH cycle.
- exec_commit high for exactly one cycle per instruction, including HLT and stalled IN/OUT.
- rst mid-FETCH or mid-EXECUTE: fetch abandoned, no commit, return to reset values next cycle.

## Test plan
- Reset, ROM returns 13'h0000 with rom_valid tied 1 → rom_addr 0x00,0x01,0x02 every 2 cycles; exec_commit pulses every 2nd cycle; opcode 0.
- rom_valid delayed 3 cycles at pc=0x05 → rom_req high 4 cycles, rom_addr held 0x05, IR latches word only on valid cycle, instr_valid 1 cycle later.
- EXECUTE with pc_load=1, pc_en=0, jump_target=0x40 → one commit, next rom_addr=0x40; pc_load=1 with pc_en=1 simultaneously → still 0x40.
- pc_en=0, halt=0, pc_load=0 (OUT), io_ready low 5 cycles then high → instr_valid high 6 cycles, single exec_commit on 6th, pc+1.
- pc=0xFF, pc_en=1 → next pc 0x00.
- halt=1 at pc=0x12 → one commit, halted=1, rom_req=0, pc stays 0x12 for 20 cycles despite toggling inputs; rst → pc=0x00, FETCH resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 8-bit computer.
// Owns the PC and IR, sequences FETCH/EXECUTE/HALTED around the control unit.
module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic [12:0]       rom_data,
  input  logic              rom_valid,
  output logic [4:0]        opcode,
  output logic [7:0]        operand,
  output logic              instr_valid,
  output logic              exec_commit,
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic              halt,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              io_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [12:0]       ir;
  logic              ir_load;

  assign rom_addr = pc;
  assign opcode   = ir[12:8];
  assign operand  = ir[7:0];

  // State, PC and IR registers; IR only loads on the FETCH->EXECUTE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= rom_data;
    end
  end

  // Next-state, next-PC and strobe decode; strobes are suppressed during rst
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_load     = 1'b0;
    rom_req     = 1'b0;
    instr_valid = 1'b0;
    exec_commit = 1'b0;
    halted      = 1'b0;
    unique case (state)
      FETCH: begin
        rom_req = 1'b1;
        if (rom_valid) begin
          ir_load    = 1'b1;
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        instr_valid = 1'b1;
        if (halt) begin
          exec_commit = 1'b1;
          state_next  = HALTED;
        end else if (pc_load) begin
          exec_commit = 1'b1;
          pc_next     = jump_target;
          state_next  = FETCH;
        end else if (pc_en || io_ready) begin
          exec_commit = 1'b1;
          pc_next     = pc + ADDR_W'(1);
          state_next  = FETCH;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
    if (rst) begin
      rom_req     = 1'b0;
      instr_valid = 1'b0;
      exec_commit = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven check of fetch_unit.
// Each table row is one clock cycle of inputs and expected outputs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic        rom_req;
  logic [12:0] rom_data;
  logic        rom_valid;
  logic [4:0]  opcode;
  logic [7:0]  operand;
  logic        instr_valid;
  logic        exec_commit;
  logic        pc_en;
  logic        pc_load;
  logic        halt;
  logic [7:0]  jump_target;
  logic        io_ready;
  logic [7:0]  pc;
  logic        halted;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_req(rom_req),
    .rom_data(rom_data), .rom_valid(rom_valid),
    .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .exec_commit(exec_commit),
    .pc_en(pc_en), .pc_load(pc_load), .halt(halt),
    .jump_target(jump_target), .io_ready(io_ready),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [12:0] data;
    logic        en;
    logic        ld;
    logic        hl;
    logic [7:0]  jt;
    logic        io;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic r, input logic rv, input logic [12:0] d,
    input logic en, input logic ld, input logic hl,
    input logic [7:0] jt, input logic io,
    input logic req, input logic [7:0] a, input logic iv,
    input logic ec, input logic hd, input logic [4:0] op,
    input logic [7:0] opd);
    vec_t t;
    t.rst = r; t.rv = rv; t.data = d;
    t.en = en; t.ld = ld; t.hl = hl;
    t.jt = jt; t.io = io;
    t.exp = {req, a, iv, ec, hd, op, opd};
    return t;
  endfunction

  function automatic logic [24:0] outs();
    return {rom_req, rom_addr, instr_valid, exec_commit,
            halted, opcode, operand};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; rom_valid = t.rv; rom_data = t.data;
    pc_en = t.en; pc_load = t.ld; halt = t.hl;
    jump_target = t.jt; io_ready = t.io;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and pc 00..02 with rom_valid tied high
    tbl.push_back(v(1,0,0,0,0,0,0,0, 0,8'h00,0,0,0,5'h00,8'h00));
    tbl.push_back(v(0,1,0,0,0,0,0,0, 1,8'h00,0,0,0,5'h00,8'h00));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,8'h00,1,1,0,5'h00,8'h00));
    tbl.push_back(v(0,1,0,0,0,0,0,0, 1,8'h01,0,0,0,5'h00,8'h00));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,8'h01,1,1,0,5'h00,8'h00));
    tbl.push_back(v(0,1,13'h1A5C,0,0,0,0,0, 1,8'h02,0,0,0,5'h00,8'h00));
    // jump to 0x05, then ROM waits 3 cycles there
    tbl.push_back(v(0,0,0,0,1,0,8'h05,0, 0,8'h02,1,1,0,5'h1A,8'h5C));
    tbl.push_back(v(0,0,13'h0FFF,0,0,0,0,0, 1,8'h05,0,0,0,5'h1A,8'h5C));
    tbl.push_back(v(0,0,13'h0FFF,1,0,0,0,1, 1,8'h05,0,0,0,5'h1A,8'h5C));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 1,8'h05,0,0,0,5'h1A,8'h5C));
    tbl.push_back(v(0,1,13'h0B33,0,0,0,0,0, 1,8'h05,0,0,0,5'h1A,8'h5C));
    // pc_load wins over pc_en
    tbl.push_back(v(0,0,0,1,1,0,8'h40,0, 0,8'h05,1,1,0,5'h0B,8'h33));
    tbl.push_back(v(0,1,13'h0E01,0,0,0,0,0, 1,8'h40,0,0,0,5'h0B,8'h33));
    // OUT stall: io_ready low 5 cycles, rom_valid noise ignored
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0,1,13'h1FFF,0,0,0,0,0, 0,8'h40,1,0,0,5'h0E,8'h01));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 0,8'h40,1,1,0,5'h0E,8'h01));
    tbl.push_back(v(0,1,0,0,0,0,0,0, 1,8'h41,0,0,0,5'h0E,8'h01));
    // wrap 0xFF -> 0x00
    tbl.push_back(v(0,0,0,0,1,0,8'hFF,0, 0,8'h41,1,1,0,5'h00,8'h00));
    tbl.push_back(v(0,1,0,0,0,0,0,0, 1,8'hFF,0,0,0,5'h00,8'h00));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,8'hFF,1,1,0,5'h00,8'h00));
    tbl.push_back(v(0,1,0,0,0,0,0,0, 1,8'h00,0,0,0,5'h00,8'h00));
    // halt at 0x12 beats pc_load and pc_en
    tbl.push_back(v(0,0,0,0,1,0,8'h12,0, 0,8'h00,1,1,0,5'h00,8'h00));
    tbl.push_back(v(0,1,13'h1F00,0,0,0,0,0, 1,8'h12,0,0,0,5'h00,8'h00));
    tbl.push_back(v(0,0,0,1,1,1,8'h77,1, 0,8'h12,1,1,0,5'h1F,8'h00));
    tbl.push_back(v(0,1,13'h0555,1,1,0,8'h33,1, 0,8'h12,0,0,1,5'h1F,8'h00));

    drive(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    next_cycle();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      next_cycle();
    end

    // HALTED holds for 20 cycles under random inputs
    for (int i = 0; i < 20; i++) begin
      rst = 1'b0;
      rom_valid = 1'($urandom);
      rom_data = 13'($urandom);
      pc_en = 1'($urandom);
      pc_load = 1'($urandom);
      halt = 1'($urandom);
      jump_target = 8'($urandom);
      io_ready = 1'($urandom);
      @(negedge clk);
      chk($sformatf("halt_hold%0d", i), 32'(outs()),
          32'({1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 5'h1F, 8'h00}));
      chk($sformatf("halt_pc%0d", i), 32'(pc), 32'h12);
      next_cycle();
    end

    // reset out of HALTED, fetch resumes at 0x00
    drive(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    next_cycle();
    drive(v(0,1,13'h0123,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    chk("rst_exit", 32'(outs()),
        32'({1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00}));
    next_cycle();

    // reset mid-EXECUTE: no commit, pc stays at reset value
    drive(v(1,0,0,1,0,0,0,1, 0,0,0,0,0,0,0));
    @(negedge clk);
    chk("rst_exec_commit", 32'(exec_commit), 32'h0);
    chk("rst_exec_ir", 32'({opcode, operand}), 32'h0123);
    next_cycle();
    drive(v(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    chk("rst_exec_after", 32'(outs()),
        32'({1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00}));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
